// File: rtl/pmem_line_responder_pkg.sv
// Shared LC-3b memory types plus line-responder state and beat constants.
package lc3b_types;

    typedef logic [15:0]  lc3b_pmem_addr;
    typedef logic [127:0] lc3b_pmem_line;
    typedef logic [15:0]  lc3b_word;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_BURST = 2'd1,
        WR_BURST = 2'd2,
        RESP     = 2'd3
    } pmem_resp_state_t;

    localparam int unsigned PMEM_BEATS  = 8;
    localparam int unsigned PMEM_BEAT_W = 3;
    localparam int unsigned PMEM_TAG_W  = 12;

    // Byte address of one 16-bit beat within a line.
    function automatic lc3b_pmem_addr pmem_beat_addr(input logic [PMEM_TAG_W-1:0]  tag,
                                                     input logic [PMEM_BEAT_W-1:0] beat);
        return {tag, beat, 1'b0};
    endfunction

endpackage

// File: rtl/pmem_line_responder_beat_buffer.sv
// Line register for the responder: parallel snapshot load, indexed beat write and beat select.
module pmem_beat_buffer
    import lc3b_types::*;
#(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned LINE_W = 128
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                load_i,
    input  logic [LINE_W-1:0]                   load_line_i,
    input  logic                                beat_we_i,
    input  logic [$clog2(LINE_W/WORD_W)-1:0]    beat_idx_i,
    input  logic [WORD_W-1:0]                   beat_wdata_i,
    output logic [LINE_W-1:0]                   line_next_o,
    output logic [WORD_W-1:0]                   beat_rdata_o
);

    localparam int unsigned BEATS = LINE_W / WORD_W;
    localparam int unsigned IDX_W = $clog2(BEATS);

    logic [LINE_W-1:0] line_q;
    logic [LINE_W-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (load_i) begin
            line_d = load_line_i;
        end else if (beat_we_i) begin
            for (int unsigned i = 0; i < BEATS; i++) begin
                if (beat_idx_i == IDX_W'(i)) begin
                    line_d[i*WORD_W +: WORD_W] = beat_wdata_i;
                end
            end
        end
    end

    always_comb begin
        beat_rdata_o = '0;
        for (int unsigned i = 0; i < BEATS; i++) begin
            if (beat_idx_i == IDX_W'(i)) begin
                beat_rdata_o = line_q[i*WORD_W +: WORD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    // Exposes the post-update line so a completing read can capture its final beat.
    assign line_next_o = line_d;

endmodule

// File: rtl/pmem_line_responder.sv
// Cache pmem line responder: services 128-bit line reads/writes as 8-beat 16-bit SRAM bursts.
// Optional macro PMEM_LAST_LINE_EN keeps the last read line to answer repeat reads without a burst.
module pmem_line_responder
    import lc3b_types::*;
#(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pmem_read,
    input  logic              pmem_write,
    input  logic [15:0]       pmem_address,
    input  logic [LINE_W-1:0] pmem_wdata,
    output logic [LINE_W-1:0] pmem_rdata,
    output logic              pmem_resp,
    output logic              sram_req,
    output logic              sram_we,
    output logic [15:0]       sram_addr,
    output logic [WORD_W-1:0] sram_wdata,
    input  logic [WORD_W-1:0] sram_rdata,
    input  logic              sram_ack
);

    pmem_resp_state_t        state_q, state_d;
    logic [PMEM_BEAT_W-1:0]  beat_q, beat_d;
    logic [PMEM_TAG_W-1:0]   line_q, line_d;
    logic [LINE_W-1:0]       rdata_q, rdata_d;

    logic                    buf_load;
    logic                    buf_beat_we;
    logic [LINE_W-1:0]       buf_line_next;
    logic [WORD_W-1:0]       buf_beat_rdata;
    logic                    last_beat;

    logic                    unused_addr_bits;
    assign unused_addr_bits = ^pmem_address[3:0];

    assign last_beat = (beat_q == '1) && sram_ack;

`ifdef PMEM_LAST_LINE_EN
    logic                    valid_q;
    logic [PMEM_TAG_W-1:0]   tag_q;
    logic [LINE_W-1:0]       hold_q;
    logic                    hit;

    assign hit = valid_q && (tag_q == pmem_address[15:4]);
`endif

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_d      = line_q;
        rdata_d     = rdata_q;
        buf_load    = 1'b0;
        buf_beat_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (pmem_write) begin
                    line_d   = pmem_address[15:4];
                    buf_load = 1'b1;
                    beat_d   = '0;
                    state_d  = WR_BURST;
                end else if (pmem_read) begin
                    line_d  = pmem_address[15:4];
                    beat_d  = '0;
                    state_d = RD_BURST;
`ifdef PMEM_LAST_LINE_EN
                    if (hit) begin
                        rdata_d = hold_q;
                        state_d = RESP;
                    end
`endif
                end
            end
            RD_BURST: begin
                if (sram_ack) begin
                    buf_beat_we = 1'b1;
                    beat_d      = beat_q + 1'b1;
                    if (last_beat) begin
                        rdata_d = buf_line_next;
                        state_d = RESP;
                    end
                end
            end
            WR_BURST: begin
                if (sram_ack) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef PMEM_LAST_LINE_EN
    // The held copy tracks the line buffer after a read, and the write snapshot on a tag match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            hold_q  <= '0;
        end else if (state_q == RD_BURST && last_beat) begin
            valid_q <= 1'b1;
            tag_q   <= line_q;
            hold_q  <= buf_line_next;
        end else if (state_q == WR_BURST && last_beat && valid_q && tag_q == line_q) begin
            hold_q  <= buf_line_next;
        end
    end
`endif

    pmem_beat_buffer #(
        .WORD_W (WORD_W),
        .LINE_W (LINE_W)
    ) u_beat_buffer (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_i       (buf_load),
        .load_line_i  (pmem_wdata),
        .beat_we_i    (buf_beat_we),
        .beat_idx_i   (beat_q),
        .beat_wdata_i (sram_rdata),
        .line_next_o  (buf_line_next),
        .beat_rdata_o (buf_beat_rdata)
    );

    assign pmem_rdata = rdata_q;
    assign pmem_resp  = (state_q == RESP);
    assign sram_req   = (state_q == RD_BURST) || (state_q == WR_BURST);
    assign sram_we    = (state_q == WR_BURST);
    assign sram_addr  = pmem_beat_addr(line_q, beat_q);
    assign sram_wdata = buf_beat_rdata;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Scoreboard bench for pmem_line_responder: queued expectations checked by a negedge monitor.
module tb_pmem_line_responder;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
    logic         sram_req, sram_we, sram_ack;
    logic [15:0]  sram_addr, sram_wdata, sram_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int stall_cfg = 0;
    int stall_cnt = 0;
    logic [15:0] rd_mul = 16'h1111;
    bit got;

    typedef struct {
        bit           is_resp;
        logic [15:0]  addr;
        logic         we;
        logic [15:0]  wd;
        logic [127:0] rdata;
        int           cyc;
    } exp_t;
    exp_t q[$];

    localparam logic [127:0] L2 = 128'h8888_7777_6666_5555_4444_3333_2222_1111;
    localparam logic [127:0] W3 = 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100;
    localparam logic [127:0] W4 = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_5A5A_A5A5;
    localparam logic [127:0] W5 = 128'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10;
    localparam logic [127:0] W6 = 128'hC0DE_0006_0005_0004_0003_0002_0001_BEEF;
    localparam logic [127:0] L7 = 128'h0808_0707_0606_0505_0404_0303_0202_0101;
    localparam logic [127:0] L9 = 128'h1818_1515_1212_0F0F_0C0C_0909_0606_0303;

    pmem_line_responder #(
        .WORD_W (16),
        .LINE_W (128)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .sram_req     (sram_req),
        .sram_we      (sram_we),
        .sram_addr    (sram_addr),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ack     (sram_ack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endfunction

    // SRAM model: ack after stall_cfg idle cycles per beat, data = rd_mul * (beat+1).
    always @(posedge clk) begin
        #1;
        if (sram_req && stall_cnt >= stall_cfg) begin
            sram_ack   = 1'b1;
            sram_rdata = 16'(rd_mul * ({13'd0, sram_addr[3:1]} + 16'd1));
            stall_cnt  = 0;
        end else begin
            sram_ack = 1'b0;
            if (sram_req) stall_cnt++;
            else          stall_cnt = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sram_req && sram_ack) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL beat_unexpected act=%h exp=none", sram_addr);
                end else begin
                    e = q.pop_front();
                    chk("beat_kind", 128'(e.is_resp), 128'd0);
                    chk("beat_addr", 128'(sram_addr), 128'(e.addr));
                    chk("beat_we",   128'(sram_we),   128'(e.we));
                    if (e.we) chk("beat_wdata", 128'(sram_wdata), 128'(e.wd));
                end
            end
            if (pmem_resp) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL resp_unexpected act=%h exp=none", pmem_rdata);
                end else begin
                    e = q.pop_front();
                    chk("resp_kind",  128'(e.is_resp), 128'd1);
                    chk("resp_rdata", pmem_rdata, e.rdata);
                    chk("resp_cycle", 128'(cyc), 128'(e.cyc));
                end
            end
        end
    end

    task automatic run_req(input bit rd, input bit wr, input logic [15:0] addr,
                           input logic [127:0] wd, input int stall, input logic [15:0] mul,
                           input bit burst, input bit chg, input logic [127:0] exp_line,
                           input int lat);
        exp_t e;
        logic [15:0] base;
        @(negedge clk);
        base = {addr[15:4], 4'h0};
        if (burst) begin
            for (int i = 0; i < 8; i++) begin
                e.is_resp = 1'b0; e.addr = base + 16'(2 * i); e.we = wr;
                e.wd = wd[16*i +: 16]; e.rdata = '0; e.cyc = 0;
                q.push_back(e);
            end
        end
        e.is_resp = 1'b1; e.addr = '0; e.we = 1'b0; e.wd = '0;
        e.rdata = exp_line; e.cyc = cyc + lat;
        q.push_back(e);
        stall_cfg = stall; rd_mul = mul;
        pmem_address = addr; pmem_wdata = wd; pmem_read = rd; pmem_write = wr;
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (chg && k == 0) begin
                pmem_wdata   = ~wd;
                pmem_address = 16'h5000;
            end
            if (pmem_resp) begin
                got = 1'b1;
                break;
            end
        end
        chk("resp_timeout", 128'(got), 128'd1);
        pmem_read = 1'b0; pmem_write = 1'b0;
    endtask

    initial begin
        int n;
        exp_t e;
        rst_n = 1'b0; pmem_read = 1'b0; pmem_write = 1'b0;
        pmem_address = '0; pmem_wdata = '0;
        sram_ack = 1'b0; sram_rdata = '0;
        #2;
        chk("reset_rdata",  pmem_rdata, '0);
        chk("reset_resp",   128'(pmem_resp), 128'd0);
        chk("reset_req",    128'(sram_req), 128'd0);
        chk("reset_we",     128'(sram_we), 128'd0);
        chk("reset_addr",   128'(sram_addr), 128'd0);
        chk("reset_wdata",  128'(sram_wdata), 128'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Read aborted by reset after three acks
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            e.is_resp = 1'b0; e.addr = 16'h3450 + 16'(2 * i); e.we = 1'b0;
            e.wd = '0; e.rdata = '0; e.cyc = 0;
            q.push_back(e);
        end
        stall_cfg = 0; rd_mul = 16'h1111;
        pmem_address = 16'h3450; pmem_read = 1'b1;
        n = 0; got = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sram_req && sram_ack) n++;
            if (n == 3) begin
                got = 1'b1;
                break;
            end
        end
        chk("abort_three_acks", 128'(got), 128'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0; pmem_read = 1'b0;
        #1;
        chk("abort_req",   128'(sram_req), 128'd0);
        chk("abort_resp",  128'(pmem_resp), 128'd0);
        chk("abort_addr",  128'(sram_addr), 128'd0);
        chk("abort_rdata", pmem_rdata, '0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        run_req(1'b1, 1'b0, 16'h1230, '0, 0, 16'h1111, 1'b1, 1'b0, L2, 9);
        run_req(1'b0, 1'b1, 16'h00F7, W3, 2, 16'h1111, 1'b1, 1'b0, L2, 25);
        run_req(1'b1, 1'b1, 16'h4000, W4, 0, 16'h1111, 1'b1, 1'b0, L2, 9);
        run_req(1'b0, 1'b1, 16'h2000, W5, 1, 16'h1111, 1'b1, 1'b1, L2, 17);
`ifdef PMEM_LAST_LINE_EN
        run_req(1'b1, 1'b0, 16'h1230, '0, 0, 16'h0101, 1'b0, 1'b0, L2, 1);
        run_req(1'b0, 1'b1, 16'h1230, W6, 0, 16'h0101, 1'b1, 1'b0, L2, 9);
        run_req(1'b1, 1'b0, 16'h1234, '0, 0, 16'h0303, 1'b0, 1'b0, W6, 1);
`else
        run_req(1'b1, 1'b0, 16'h1230, '0, 0, 16'h0101, 1'b1, 1'b0, L7, 9);
        run_req(1'b0, 1'b1, 16'h1230, W6, 0, 16'h0101, 1'b1, 1'b0, L7, 9);
        run_req(1'b1, 1'b0, 16'h1234, '0, 0, 16'h0303, 1'b1, 1'b0, L9, 9);
`endif
        @(negedge clk); @(negedge clk);
        chk("queue_drained", 128'(q.size()), 128'd0);
        chk("final_idle_req", 128'(sram_req), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1);
    end

endmodule
